pipelined_addsub: RTL and testbench
===================================

// Module: pipelined_addsub
// PURPOSE
//  Parametrised, pipelined two's-complement adder/subtractor with a valid/ready handshake.
//  Splits a WIDTH-bit add/sub into STAGES ripple chunks, one chunk per clock, so WIDTH scales without lengthening the critical path.
//  Reports the full flag set (carryout, overflow, zero, negative) and carries a user tag.
//  Sits between the register-read and writeback stages of the CPU datapath.
// PARAMETERS
//  WIDTH   32  operand/result width in bits; must be a multiple of STAGES
//  STAGES  4   pipeline depth = number of carry chunks (1..WIDTH); CHUNK = WIDTH/STAGES
//  TAG_W   4   width of the opaque tag carried alongside each operation
// PORTS
//  clk        in   1       single clock; all state changes on its rising edge
//  reset      in   1       synchronous, active-high reset
//  in_valid   in   1       operation presented on a/b/subtract/in_tag
//  in_ready   out  1       block accepts the operation this cycle
//  a          in   WIDTH   first operand, two's complement
//  b          in   WIDTH   second operand, two's complement
//  subtract   in   1       1: a-b, 0: a+b
//  in_tag     in   TAG_W   tag returned unchanged with the result
//  out_valid  out  1       result presented
//  out_ready  in   1       downstream accepts the result this cycle
//  sum        out  WIDTH   result
//  carryout   out  1       carry out of bit WIDTH-1 (on subtract: 1 = no borrow)
//  overflow   out  1       signed overflow = carry into MSB XOR carry out of MSB
//  zero       out  1       sum == 0
//  negative   out  1       sum[WIDTH-1]
//  out_tag    out  TAG_W   tag of the presented result
// BEHAVIOUR
//  - Arithmetic: sum = a + (b XOR {WIDTH{subtract}}) + subtract, modulo 2^WIDTH; identical across all parameter values.
//  - Stage k (0..STAGES-1) computes bits [k*CHUNK +: CHUNK] from the registered carry of stage k-1; stage 0 takes carry-in = subtract.
//  - Unprocessed high chunks of a/b and subtract travel with the op; result chunks are de-skewed so all bits of one op emerge together.
//  - Latency: exactly STAGES cycles from the in_valid&&in_ready edge to out_valid, when out_ready stays high.
//  - Throughput: one op per cycle when out_ready stays high.
//  - Global stall: advance = !out_valid || out_ready; in_ready = advance.
//    - When advance=0, every stage register (data, valid, tag) holds.
//    - Bubbles are not compressed during a stall.
//  - out_valid, sum and all flags stay stable while out_valid && !out_ready.
//  - Flags are computed in the final stage from the completed sum/carries.
//  - Ordering: results leave in acceptance order, never dropped or duplicated.
//  - Reset: all stage valid bits clear; out_valid=0, sum=0, carryout/overflow/zero/negative=0, out_tag=0 from the cycle after reset is sampled high.
//    - in_ready=1 while reset is low and the pipe is empty.
//    - Reset mid-operation discards every in-flight op.
//  - in_valid while in_ready=0: the op is not accepted; the source must hold it.
//  - STAGES=1: purely one-register design; latency 1.
// CONFIGURATION
//  ADDSUB_SATURATE_EN defined:
//    - On signed overflow, sum clamps to 2^(WIDTH-1)-1 (positive overflow) or -2^(WIDTH-1) (negative overflow).
//    - overflow still reports 1; zero/negative follow the clamped sum.
//    - Extra output port saturated (1 bit, reset 0) is high when clamping occurred.
//  Macro undefined: wrap-around result; no saturated port.
// STRUCTURE
//  - Package addsub_pkg:
//    - addsub_flags_t struct {carryout, overflow, zero, negative}
//    - default WIDTH/STAGES/TAG_W localparams
//    - function chunk_lo(k, chunk) returning the chunk base index
//  - Sub-module addsub_chunk: combinational CHUNK-bit ripple adder.
//    - Inputs: a, b, subtract, carry-in.
//    - Outputs: sum, carry-out, carry into the chunk MSB.
//    - Instantiated STAGES times via generate.
//  - Top level holds the skew/de-skew registers, valid/tag pipeline, stall logic and final flag stage.
// TESTING  (WIDTH=32, STAGES=4 unless noted)
//  1. Add 0x7FFFFFFF+0x00000001, out_ready=1
//     -> after exactly 4 cycles: sum=0x80000000, overflow=1, carryout=0, negative=1, zero=0.
//  2. Sub 5-5 -> sum=0, zero=1, carryout=1, overflow=0.
//     Sub 0-1 -> sum=0xFFFFFFFF, carryout=0, negative=1.
//  3. Chunk-boundary carry 0x000000FF+0x00000001, then 0xFFFFFFFF+0x00000001
//     -> 0x00000100; 0x00000000 with carryout=1, zero=1.
//  4. Issue 16 random ops back-to-back with out_ready toggling pseudo-randomly
//     -> results match the reference model, in order, tags preserved, none lost or duplicated.
//     Outputs stay stable during stalls.
//  5. Assert reset for 1 cycle with 3 ops in flight
//     -> out_valid=0 and all outputs 0 next cycle; no stale result ever appears.
//  6. ADDSUB_SATURATE_EN defined:
//     - 0x7FFFFFFF+1 -> sum=0x7FFFFFFF, saturated=1, overflow=1.
//     - 0x80000000-1 -> sum=0x80000000, saturated=1.
//     Also repeat tests 1-3 with STAGES=1 and STAGES=32.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared types and defaults for the pipelined adder/subtractor.
package addsub_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_STAGES = 4;
    localparam int DEF_TAG_W  = 4;

    typedef struct packed {
        logic carryout;
        logic overflow;
        logic zero;
        logic negative;
    } addsub_flags_t;

    // Base bit index of carry chunk k.
    function automatic int chunk_lo(input int k, input int chunk);
        return k * chunk;
    endfunction

endpackage

// File: rtl/addsub_chunk.sv
// Combinational W-bit ripple add/sub slice; subtract inverts b, the caller supplies carry-in.
module addsub_chunk
    import addsub_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         subtract,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         cmsb
);

    logic [W:0]   c;
    logic [W-1:0] bx;

    always_comb begin
        bx   = b ^ {W{subtract}};
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < W; i++) begin
            sum[i]   = a[i] ^ bx[i] ^ c[i];
            c[i + 1] = (a[i] & bx[i]) | (a[i] & c[i]) | (bx[i] & c[i]);
        end
    end

    assign cout = c[W];
    assign cmsb = c[W-1];

endmodule

// File: rtl/pipelined_addsub.sv
// STAGES-deep chunked add/sub with valid/ready handshake, flags and tag.
// Define ADDSUB_SATURATE_EN to clamp on signed overflow and expose the saturated port.
module pipelined_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES,
    parameter int TAG_W  = DEF_TAG_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             subtract,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carryout,
    output logic             overflow,
    output logic             zero,
    output logic             negative,
    output logic [TAG_W-1:0] out_tag
`ifdef ADDSUB_SATURATE_EN
    ,
    output logic             saturated
`endif
);

    localparam int CHUNK = WIDTH / STAGES;

    logic          advance;
    logic [STAGES:1] vld_pipe;
    addsub_flags_t flg;

    // Whole pipe moves as one; a held result freezes every stage.
    assign advance   = !vld_pipe[STAGES] || out_ready;
    assign in_ready  = advance;
    assign out_valid = vld_pipe[STAGES];
    assign carryout  = flg.carryout;
    assign overflow  = flg.overflow;
    assign zero      = flg.zero;
    assign negative  = flg.negative;

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int LO = chunk_lo(k, CHUNK);
        localparam int SW = LO + CHUNK;

        // sa/sb hold only the not-yet-processed operand bits; nsum the finished low bits.
        logic [WIDTH-LO-1:0] sa, sb;
        logic                ssub, scin, svld;
        logic [TAG_W-1:0]    stag;
        logic [SW-1:0]       nsum;
        logic [CHUNK-1:0]    csum;
        logic                cco, ccm;

        addsub_chunk #(.W(CHUNK)) u_chunk (
            .a        (sa[CHUNK-1:0]),
            .b        (sb[CHUNK-1:0]),
            .subtract (ssub),
            .cin      (scin),
            .sum      (csum),
            .cout     (cco),
            .cmsb     (ccm)
        );

        if (k == 0) begin : g_head
            assign sa   = a;
            assign sb   = b;
            assign ssub = subtract;
            assign scin = subtract;
            assign svld = in_valid;
            assign stag = in_tag;
            assign nsum = csum;
        end else begin : g_body
            assign sa   = g_st[k-1].g_mid.a_r;
            assign sb   = g_st[k-1].g_mid.b_r;
            assign ssub = g_st[k-1].g_mid.sub_r;
            assign scin = g_st[k-1].g_mid.cry_r;
            assign svld = vld_pipe[k];
            assign stag = g_st[k-1].g_mid.tag_r;
            assign nsum = {csum, g_st[k-1].g_mid.sum_r};
        end

        if (k < STAGES - 1) begin : g_mid
            logic [WIDTH-SW-1:0] a_r, b_r;
            logic                sub_r, cry_r;
            logic [TAG_W-1:0]    tag_r;
            logic [SW-1:0]       sum_r;

            always_ff @(posedge clk) begin
                if (reset) begin
                    a_r           <= '0;
                    b_r           <= '0;
                    sub_r         <= 1'b0;
                    cry_r         <= 1'b0;
                    tag_r         <= '0;
                    sum_r         <= '0;
                    vld_pipe[k+1] <= 1'b0;
                end else if (advance) begin
                    a_r           <= sa[WIDTH-LO-1:CHUNK];
                    b_r           <= sb[WIDTH-LO-1:CHUNK];
                    sub_r         <= ssub;
                    cry_r         <= cco;
                    tag_r         <= stag;
                    sum_r         <= nsum;
                    vld_pipe[k+1] <= svld;
                end
            end
        end else begin : g_fin
            logic             ov;
            logic [WIDTH-1:0] res;

            assign ov = cco ^ ccm;
`ifdef ADDSUB_SATURATE_EN
            // Wrapped MSB set on overflow means two positives overflowed upward.
            assign res = !ov ? nsum :
                         nsum[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
`else
            assign res = nsum;
`endif

            // Output registers only load real ops so bubbles never disturb sum/flags.
            always_ff @(posedge clk) begin
                if (reset) begin
                    vld_pipe[k+1] <= 1'b0;
                    sum           <= '0;
                    flg           <= '0;
                    out_tag       <= '0;
`ifdef ADDSUB_SATURATE_EN
                    saturated     <= 1'b0;
`endif
                end else if (advance) begin
                    vld_pipe[k+1] <= svld;
                    if (svld) begin
                        sum          <= res;
                        flg.carryout <= cco;
                        flg.overflow <= ov;
                        flg.zero     <= (res == '0);
                        flg.negative <= res[WIDTH-1];
                        out_tag      <= stag;
`ifdef ADDSUB_SATURATE_EN
                        saturated    <= ov;
`endif
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench: directed corner ops, randomized stalled traffic against a scoreboard, reset flush.
module tb_pipelined_addsub;
    import addsub_pkg::*;

    parameter  int STAGES = DEF_STAGES;
    localparam int WIDTH  = 32;
    localparam int TAG_W  = DEF_TAG_W;
`ifdef ADDSUB_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             subtract = 1'b0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] sum;
    logic             carryout, overflow, zero, negative;
    logic [TAG_W-1:0] out_tag;
    logic             sat_o;

    pipelined_addsub #(.WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .subtract  (subtract),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carryout  (carryout),
        .overflow  (overflow),
        .zero      (zero),
        .negative  (negative),
        .out_tag   (out_tag)
`ifdef ADDSUB_SATURATE_EN
        ,
        .saturated (sat_o)
`endif
    );
`ifndef ADDSUB_SATURATE_EN
    assign sat_o = 1'b0;
`endif

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             co, ov, z, n, sat;
        logic [TAG_W-1:0] tag;
    } exp_t;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sbq[$];
    logic [TAG_W-1:0] tag_ctr = '0;

    task automatic chk(input string tg, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tg, got, exp, $time);
        end
    endtask

    // Reference from signed/unsigned integer arithmetic on 64-bit values.
    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic s, input logic [TAG_W-1:0] t);
        exp_t   e;
        longint ux, uy, sx, sy, sr, ur, mx, mn, m;
        m  = longint'(1) << WIDTH;
        mx = (longint'(1) << (WIDTH - 1)) - 1;
        mn = -(longint'(1) << (WIDTH - 1));
        ux = longint'(x);
        uy = longint'(y);
        sx = x[WIDTH-1] ? ux - m : ux;
        sy = y[WIDTH-1] ? uy - m : uy;
        sr = s ? sx - sy : sx + sy;
        ur = s ? ux - uy : ux + uy;
        e.co  = s ? (ux >= uy) : (ur >= m);
        e.ov  = (sr > mx) || (sr < mn);
        e.sum = ur[WIDTH-1:0];
        e.sat = 1'b0;
        if (SAT && e.ov) begin
            e.sat = 1'b1;
            e.sum = (sr > mx) ? mx[WIDTH-1:0] : mn[WIDTH-1:0];
        end
        e.z   = (e.sum == '0);
        e.n   = e.sum[WIDTH-1];
        e.tag = t;
        return e;
    endfunction

    task automatic cyc1();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_dir(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb2, input logic ts,
                           input logic [WIDTH-1:0] esum, input logic eco, input logic eov,
                           input logic ez, input logic en, input logic esat);
        int lat;
        logic [TAG_W-1:0] t;
        t = tag_ctr;
        tag_ctr++;
        a = ta; b = tb2; subtract = ts; in_tag = t; in_valid = 1'b1; out_ready = 1'b1;
        #1 chk("dir_in_ready", in_ready, 1'b1);
        cyc1();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 4 * STAGES + 4) begin
            cyc1();
            lat++;
        end
        chk("dir_latency", lat, STAGES);
        chk("dir_sum", sum, esum);
        chk("dir_carryout", carryout, eco);
        chk("dir_overflow", overflow, eov);
        chk("dir_zero", zero, ez);
        chk("dir_negative", negative, en);
        chk("dir_tag", out_tag, t);
        if (SAT) chk("dir_saturated", sat_o, esat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   recv, sent;
        bit   acc, con, prev_stall;
        logic [WIDTH-1:0] p_sum;
        logic [3:0] p_flg;
        logic [TAG_W-1:0] p_tag;
        exp_t e;

        // Reset state
        @(negedge clk);
        cyc1();
        cyc1();
        reset = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_sum", sum, '0);
        chk("rst_flags", {carryout, overflow, zero, negative}, 4'b0);
        chk("rst_tag", out_tag, '0);
        if (SAT) chk("rst_saturated", sat_o, 1'b0);
        @(negedge clk);

        // Directed corners
        run_dir(32'h7FFFFFFF, 32'h00000001, 1'b0, SAT ? 32'h7FFFFFFF : 32'h80000000,
                1'b0, 1'b1, 1'b0, !SAT, 1'b1);
        run_dir(32'h00000005, 32'h00000005, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        run_dir(32'h00000000, 32'h00000001, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        run_dir(32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_dir(32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        run_dir(32'h80000000, 32'h00000001, 1'b1, SAT ? 32'h80000000 : 32'h7FFFFFFF,
                1'b1, 1'b1, 1'b0, SAT, 1'b1);
        cyc1();

        // Random traffic with stalls
        recv = 0; sent = 0; prev_stall = 1'b0;
        p_sum = '0; p_flg = '0; p_tag = '0;
        for (int c = 0; c < 3000 && recv < 16; c++) begin
            if (!in_valid && sent < 16 && $urandom_range(0, 3) != 0) begin
                a = WIDTH'($urandom);
                b = WIDTH'($urandom);
                if ($urandom_range(0, 3) == 0) a[WIDTH-2:0] = '1;
                if ($urandom_range(0, 3) == 0) b = WIDTH'($urandom_range(0, 2));
                subtract = 1'($urandom_range(0, 1));
                in_tag = tag_ctr;
                tag_ctr++;
                in_valid = 1'b1;
            end
            out_ready = 1'($urandom_range(0, 1));
            #1;
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1'b1);
                chk("stall_sum", sum, p_sum);
                chk("stall_flags", {carryout, overflow, zero, negative}, p_flg);
                chk("stall_tag", out_tag, p_tag);
            end
            acc = in_valid && in_ready;
            con = out_valid && out_ready;
            if (out_valid && sbq.size() == 0) chk("spurious_valid", out_valid, 1'b0);
            else if (con) begin
                e = sbq.pop_front();
                chk("rand_sum", sum, e.sum);
                chk("rand_flags", {carryout, overflow, zero, negative}, {e.co, e.ov, e.z, e.n});
                chk("rand_tag", out_tag, e.tag);
                if (SAT) chk("rand_saturated", sat_o, e.sat);
                recv++;
            end
            if (acc) begin
                sbq.push_back(model(a, b, subtract, in_tag));
                sent++;
            end
            prev_stall = out_valid && !out_ready;
            p_sum = sum; p_flg = {carryout, overflow, zero, negative}; p_tag = out_tag;
            cyc1();
            if (acc) in_valid = 1'b0;
        end
        chk("rand_received", recv, 16);
        chk("rand_leftover", sbq.size(), 0);

        // Reset with ops in flight
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = WIDTH'($urandom); b = WIDTH'($urandom) | 1; subtract = 1'b0;
            in_tag = tag_ctr; tag_ctr++; in_valid = 1'b1;
            cyc1();
        end
        in_valid = 1'b0;
        reset = 1'b1;
        cyc1();
        reset = 1'b0;
        #1;
        chk("flush_out_valid", out_valid, 1'b0);
        chk("flush_sum", sum, '0);
        chk("flush_flags", {carryout, overflow, zero, negative}, 4'b0);
        chk("flush_tag", out_tag, '0);
        chk("flush_in_ready", in_ready, 1'b1);
        for (int i = 0; i < 2 * STAGES + 2; i++) begin
            cyc1();
            #1 chk("flush_no_stale", out_valid, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
